// File: rtl/frame_ram_reader_pkg.sv
// Shared constants, state encoding and length clamp for the frame RAM reader.
package frame_ram_pkg;
  localparam int ADDR_W  = 12;
  localparam int DEPTH   = 4096;
  localparam int LEN_W   = 6;
  localparam int MAX_LEN = 32;
  localparam int IDX_W   = $clog2(MAX_LEN);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len6);
    return (len6 > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len6;
  endfunction
endpackage

// File: rtl/frame_ram_reader_if.sv
// Custom-instruction handshake between the NIOS core (master) and the reader (slave).
interface frame_ram_reader_if;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  modport master (output start, dataa, datab, input result, done);
  modport slave  (input start, dataa, datab, output result, done);
endinterface

// File: rtl/frame_ram_reader_rd_lat_pipe.sv
// Delay line that tracks which result bit each outstanding RAM read belongs to.
module rd_lat_pipe
  import frame_ram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);
  logic [RD_LAT-1:0] vld;
  logic [IDX_W-1:0]  idx_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
    end else begin
      vld[0]   <= in_valid;
      idx_q[0] <= in_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i]   <= vld[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_idx   = idx_q[RD_LAT-1];
endmodule

// File: rtl/frame_ram_reader.sv
// Reads up to 32 consecutive pixel bits from the frame RAM and packs them into result.
//   state | meaning
//   IDLE  | waiting for start, result held
//   ISSUE | one read address per cycle, len cycles
//   DRAIN | RD_LAT cycles for the last reads to return
//   DONE  | done pulse, result valid
module frame_ram_reader
  import frame_ram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  frame_ram_reader_if.slave   ci,
  output logic [ADDR_W-1:0]   rdaddress,
  input  logic                q,
  output logic                rd_active
);
  localparam logic [1:0] DRAIN_LOAD = 2'(RD_LAT - 1);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_in, len_q;
  logic [IDX_W-1:0] idx;
  logic [1:0]       drain_cnt;
  logic [31:0]      result_q;
  logic             pipe_valid;
  logic [IDX_W-1:0] pipe_idx;
  logic             unused;

  assign len_in = clamp_len(ci.datab[LEN_W-1:0]);
  assign unused = ^{ci.dataa[31:ADDR_W], ci.datab[31:LEN_W]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (ci.start) state_nxt = (len_in == '0) ? DONE : ISSUE;
      ISSUE: if (LEN_W'(idx) == len_q - LEN_W'(1)) state_nxt = DRAIN;
      DRAIN: if (drain_cnt == 2'd0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      result_q  <= '0;
      rdaddress <= '0;
      idx       <= '0;
      len_q     <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (ci.start) begin
          result_q  <= '0;
          len_q     <= len_in;
          rdaddress <= ci.dataa[ADDR_W-1:0];
          idx       <= '0;
        end
        ISSUE: begin
          rdaddress <= rdaddress + ADDR_W'(1);
          idx       <= idx + IDX_W'(1);
          drain_cnt <= DRAIN_LOAD;
        end
        DRAIN: drain_cnt <= drain_cnt - 2'd1;
        default: ;
      endcase
      // returns only arrive in ISSUE/DRAIN, never on the IDLE clear
      if (pipe_valid) result_q[pipe_idx] <= q;
    end
  end

  rd_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (state == ISSUE),
    .in_idx    (idx),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx)
  );

  assign rd_active = (state == ISSUE) || (state == DRAIN);
  assign ci.done   = (state == DONE);
  assign ci.result = result_q;
endmodule

// File: tb/tb_frame_ram_reader.sv
// Scoreboard bench for frame_ram_reader with RD_LAT=1 and RD_LAT=3 instances.
module tb_frame_ram_reader;
  import frame_ram_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_ram_reader_if ci1 ();
  frame_ram_reader_if ci3 ();
  logic [ADDR_W-1:0] rda1, rda3;
  logic q1, q3, act1, act3;

  frame_ram_reader #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .ci(ci1), .rdaddress(rda1), .q(q1), .rd_active(act1));
  frame_ram_reader #(.RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .ci(ci3), .rdaddress(rda3), .q(q3), .rd_active(act3));

  logic mem1 [DEPTH];
  logic mem3 [DEPTH];
  logic [2:0] qp1, qp3;
  always @(posedge clk) begin
    qp1 <= {qp1[1:0], mem1[rda1]};
    qp3 <= {qp3[1:0], mem3[rda3]};
  end
  assign q1 = qp1[0];
  assign q3 = qp3[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb1[$];
  exp_t sb3[$];
  logic [ADDR_W-1:0] addr_log[$];
  int total = 0, bad = 0;
  int ndone1 = 0, nact1 = 0, ndone3 = 0, nact3 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input int which, input int base, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++)
      r[i] = (which == 3) ? mem3[(base + i) % DEPTH] : mem1[(base + i) % DEPTH];
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (act1) begin
      nact1++;
      addr_log.push_back(rda1);
    end
    if (act3) nact3++;
    if (ci1.done === 1'b1) begin
      ndone1++;
      if (sb1.size() == 0) chk("spurious_done1", 32'(sb1.size()), 1);
      else begin
        e = sb1.pop_front();
        chk("result1", ci1.result, e.res);
        chk("done_cyc1", 32'(cyc), 32'(e.at));
        chk("act_at_done1", 32'(act1), 0);
      end
    end
    if (ci3.done === 1'b1) begin
      ndone3++;
      if (sb3.size() == 0) chk("spurious_done3", 32'(sb3.size()), 1);
      else begin
        e = sb3.pop_front();
        chk("result3", ci3.result, e.res);
        chk("done_cyc3", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic xfer(input int which, input int base, input int db);
    exp_t e;
    logic [5:0] l6;
    int n, lat;
    l6 = db[5:0];
    n = (l6 > 6'd32) ? 32 : int'(l6);
    lat = (which == 3) ? 3 : 1;
    e.res = model(which, base, n);
    e.at = cyc + ((n == 0) ? 1 : n + lat + 1);
    if (which == 3) begin
      ci3.dataa = base; ci3.datab = db; ci3.start = 1'b1;
      sb3.push_back(e);
    end else begin
      ci1.dataa = base; ci1.datab = db; ci1.start = 1'b1;
      sb1.push_back(e);
    end
    @(negedge clk);
    ci1.start = 1'b0;
    ci3.start = 1'b0;
  endtask

  task automatic wait_drain(input int which);
    for (int i = 0; i < 200; i++) begin
      if ((which == 3 ? sb3.size() : sb1.size()) == 0) break;
      @(negedge clk);
    end
    chk("timeout", 32'(which == 3 ? sb3.size() : sb1.size()), 0);
    @(negedge clk);
  endtask

  task automatic fill_alt1();
    for (int i = 0; i < DEPTH; i++) mem1[i] = (i % 2 == 0);
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_addr [4];
    ci1.start = 0; ci1.dataa = 0; ci1.datab = 0;
    ci3.start = 0; ci3.dataa = 0; ci3.datab = 0;
    fill_alt1();
    for (int i = 0; i < DEPTH; i++) mem3[i] = 1'b1;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_result", ci1.result, 0);
    chk("rst_done", 32'(ci1.done), 0);
    chk("rst_rdaddr", 32'(rda1), 0);
    chk("rst_active", 32'(act1), 0);
    chk("rst_result3", ci3.result, 0);
    reset = 1'b0;
    @(negedge clk);

    // full 32-bit read of alternating pattern
    nact1 = 0;
    xfer(1, 0, 32);
    wait_drain(1);
    chk("t1_result_lit", ci1.result, 32'h5555_5555);
    chk("t1_active_cycles", 32'(nact1), 33);

    // wrap across 4095 -> 0
    for (int i = 0; i < DEPTH; i++) mem1[i] = 1'b0;
    mem1[4094] = 1; mem1[4095] = 1; mem1[0] = 0; mem1[1] = 1;
    exp_addr[0] = 12'd4094; exp_addr[1] = 12'd4095; exp_addr[2] = 12'd0; exp_addr[3] = 12'd1;
    addr_log.delete();
    xfer(1, 4094, 4);
    wait_drain(1);
    chk("t2_result_lit", ci1.result, 32'h0000_000B);
    chk("t2_addr_cnt", 32'(addr_log.size()), 5);
    if (addr_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t2_rdaddr", 32'(addr_log[i]), 32'(exp_addr[i]));

    // zero length clears previous result, never touches the port
    nact1 = 0;
    xfer(1, 0, 0);
    wait_drain(1);
    chk("t3_active_cycles", 32'(nact1), 0);

    // 40 clamps to 32
    fill_alt1();
    xfer(1, 5, 40);
    wait_drain(1);
    chk("t4_result_lit", ci1.result, 32'hAAAA_AAAA);

    // start pulses while busy are ignored
    ndone1 = 0;
    xfer(1, 0, 32);
    repeat (4) @(negedge clk);
    ci1.dataa = 1; ci1.datab = 3; ci1.start = 1;
    @(negedge clk); ci1.start = 0;
    repeat (4) @(negedge clk);
    ci1.dataa = 1; ci1.datab = 3; ci1.start = 1;
    @(negedge clk); ci1.start = 0;
    wait_drain(1);
    repeat (3) @(negedge clk);
    chk("t5_done_count", 32'(ndone1), 1);
    chk("t5_result_held", ci1.result, 32'h5555_5555);

    // reset mid-transfer aborts it
    ndone1 = 0;
    xfer(1, 0, 32);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb1.delete();
    chk("t6_result", ci1.result, 0);
    chk("t6_done", 32'(ci1.done), 0);
    chk("t6_active", 32'(act1), 0);
    repeat (40) @(negedge clk);
    chk("t6_no_done", 32'(ndone1), 0);
    xfer(1, 100, 8);
    wait_drain(1);
    chk("t6_result_lit", ci1.result, 32'h0000_0055);

    // deeper read latency
    nact3 = 0;
    xfer(3, 7, 16);
    wait_drain(3);
    chk("t7_result_lit", ci3.result, 32'h0000_FFFF);
    chk("t7_active_cycles", 32'(nact3), 19);
    chk("t7_done_count", 32'(ndone3), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
